// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants.
// Contents: fetch FSM state encoding, buffer entry width ({pc, instr}), instruction size in bytes.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FAULT
    } fetch_state_t;

    localparam int FETCH_ENTRY_W = 64;
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO holding {pc, instr} fetch entries.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, pop     write/read requests (ignored when full/empty, or during flush)
//   flush         discards all entries; overrides push and pop
//   din, dout     entry in / head entry out (dout holds its last value when empty)
//   full, empty   occupancy flags
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [FETCH_ENTRY_W-1:0] din,
    output logic [FETCH_ENTRY_W-1:0] dout,
    output logic                     full,
    output logic                     empty
);

    logic [1:0]               count;
    logic [FETCH_ENTRY_W-1:0] tail;
    logic                     do_pop;
    logic                     do_push;

    assign empty   = count == 2'd0;
    assign full    = count == 2'd2;
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    // dout is the head register itself, so the consumer never sees a path from din.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            dout  <= '0;
            tail  <= '0;
        end else begin
            count <= flush ? 2'd0 : count + {1'b0, do_push} - {1'b0, do_pop};
            if (do_pop)
                dout <= full ? tail : (do_push ? din : dout);
            else if (do_push && empty)
                dout <= din;
            if (do_push && (full || (count == 2'd1 && !do_pop)))
                tail <= din;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: fetch-stage PC sequencer feeding decode through a 2-entry buffer.
// Optional feature: define FETCH_RANGE_CHECK_EN to fault on PCs outside the instruction memory.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   en                       fetch enable
//   imem_addr, imem_instr    combinational instruction memory address / returned word
//   redirect_valid/_pc       branch/jump redirect (target bits [1:0] ignored)
//   out_valid/_ready         decode handshake; out_pc/out_instr carry the head entry
//   fault, fault_pc          sticky range fault flag and faulting PC
module fetch_controller
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * INSTR_BYTES);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic         full;
    logic         empty;
    logic         pop;
    logic         redir;
    logic         push;
    logic         bad;
    logic         take_fault;
    logic         unused_bits;

    assign imem_addr = pc;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

`ifdef FETCH_RANGE_CHECK_EN
    assign bad = pc >= IMEM_LIMIT;
    assign unused_bits = ^redirect_pc[1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault    <= 1'b0;
            fault_pc <= 32'h0;
        end else if (take_fault) begin
            fault    <= 1'b1;
            fault_pc <= pc;
        end else if (redir) begin
            fault    <= 1'b0;
        end
    end
`else
    assign bad = 1'b0;
    assign unused_bits = ^{redirect_pc[1:0], take_fault, IMEM_LIMIT};
    assign fault    = 1'b0;
    assign fault_pc = 32'h0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // A redirect taken in FETCH still honours en; only FAULT forces FETCH.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = en ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_next = take_fault ? ST_FAULT : (en ? ST_FETCH : ST_IDLE);
            ST_FAULT: state_next = redir ? ST_FETCH : ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        redir      = redirect_valid & (state != ST_IDLE);
        take_fault = (state == ST_FETCH) & ~redir & bad;
        push       = (state == ST_FETCH) & ~redir & ~bad & (~full | pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (redir)
            pc <= {redirect_pc[31:2], 2'b00};
        else if (push)
            pc <= pc + 32'(INSTR_BYTES);
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   ({pc, imem_instr}),
        .dout  ({out_pc, out_instr}),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the combinational instruction memory for the pipeline's fetch stage. Holds the program counter, drives the memory address, and captures `{pc, instr}` pairs into a 2-entry buffer presented to decode through a valid/ready handshake. Handles branch/jump redirects with buffer flush and, optionally, out-of-range fetch faults.

## Interface
- `RESET_PC`, 32'h00000000, PC loaded at reset.
- `IMEM_WORDS`, 256, instruction memory depth in 32-bit words; legal byte range is `[0, IMEM_WORDS*4)`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  fetch enable.
- `imem_addr`  out  32  byte address to the instruction memory; always equals the PC register.
- `imem_instr`  in  32  instruction word returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored (forced to 0).
- `out_valid`  out  1  buffer head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_pc`  out  32  PC of the head entry.
- `out_instr`  out  32  instruction of the head entry.
- `fault`  out  1  sticky out-of-range fault flag.
- `fault_pc`  out  32  PC that caused the fault.

## Operation
- States: IDLE, FETCH, FAULT.
- IDLE → FETCH when `en`=1. FETCH → IDLE when `en`=0; the PC and buffer are retained, and the buffer still drains.
- In FETCH, push occurs when the buffer is not full, or when it is full and a pop happens in the same cycle. On push: entry `{pc, imem_instr}` is written and `pc <= pc + 4` (modulo 2^32).
- Pop occurs when `out_valid & out_ready`.
- Redirect has the highest priority and is accepted in any state except IDLE:
  - The buffer is flushed, discarding any pop that cycle.
  - `pc <= {redirect_pc[31:2], 2'b00}`. No push occurs that cycle.
  - From FAULT, the controller returns to FETCH and clears `fault`.
- Range fault (see Configuration): in FETCH, if `pc >= IMEM_WORDS*4`, no push occurs and the PC holds. The controller enters FAULT with `fault`=1 and `fault_pc`=pc. In FAULT the buffer continues draining; only a redirect or reset exits.
- Buffer occupancy is 0..2. Empty: `out_valid`=0, and `out_pc`/`out_instr` hold their last values. No push or pop occurs beyond these bounds.
- Reset values:
  - `pc`/`imem_addr` = `RESET_PC`.
  - Buffer empty; `out_valid`=0; `out_pc`=0; `out_instr`=0.
  - `fault`=0; `fault_pc`=0; state IDLE.
- Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.

## Timing
- Fetch latency: the PC is presented in cycle N and the entry is visible at `out_valid`/`out_pc` in cycle N+1.
- Throughput is 1 instruction/cycle when `out_ready` is held high.
- Redirect in cycle N: the first new-target entry becomes valid in cycle N+2. `out_valid`=0 in cycle N+1.
- A fault is detected in cycle N and `fault`=1 in cycle N+1.
- `out_*` are driven directly from buffer registers, with no combinational path from `imem_instr`. `imem_addr` is driven directly from the PC register.

## Configuration
- `FETCH_RANGE_CHECK_EN` defined: the range fault is implemented as described.
- Not defined: there is no range check. `fault` and `fault_pc` are tied to 0, FAULT is unreachable, and the PC increments freely with 2^32 wrap.

## Structure
- Shared package `riscv_pkg`:
  - fetch state encoding (IDLE/FETCH/FAULT)
  - `FETCH_ENTRY_W` = 64 (`{pc, instr}`)
  - `INSTR_BYTES` = 4
- Sub-module `fetch_buffer`: a 2-entry synchronous FIFO with `push`, `pop`, `flush`, `full`, `empty`, 64-bit data and asynchronous reset.

## Test plan
- Reset then `en`=1, `out_ready`=1: entries emerge from cycle 2 in the sequence `out_pc` 0x0, 0x4, 0x8, with `out_instr` matching the memory words.
- `out_ready`=0 for 4 cycles: the buffer fills after 2 pushes, the PC holds at 0x8 and `imem_addr` stays at 0x8. Releasing `out_ready` resumes with pc 0x0 → 0x4 → 0x8 and no loss or duplication.
- Redirect to 0x00000042 while the buffer is full: the buffer is flushed, the next cycle has `out_valid`=0, and the following entry has `out_pc`=0x40.
- Redirect and pop in the same cycle: the pop is discarded and the flush wins, giving occupancy 0.
- `FETCH_RANGE_CHECK_EN` with `IMEM_WORDS`=256, redirect to 0x3FC: entry 0x3FC is delivered, then `fault`=1 with `fault_pc`=0x400. A subsequent redirect to 0x0 clears `fault` and resumes fetching.
- Assert `rst` asynchronously while 2 entries are buffered: `out_valid` drops before the next edge, and `imem_addr`=`RESET_PC`.
